// File: rtl/cordic_iterative.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cordic_iterative                                            |
// | Description : Iterative CORDIC engine. One shift-add micro-rotation per   |
// |               clock on a single (x, y, z) set, rotation or vectoring      |
// |               mode, full-circle range via a +/-90 degree pre-rotation.    |
// | Ports       : clk, rst_n        - clock, async active-low reset           |
// |               start, mode       - request (taken when not busy), 0=rot    |
// |               x_in, y_in, z_in  - operands (z: 2^31 == pi)                |
// |               busy, done        - in flight / one-cycle result strobe     |
// |               x_out, y_out      - WIDTH+2 results, CORDIC gain included   |
// |               z_out             - residual or accumulated angle           |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module cordic_iterative #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic        [31:0]      z_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic        [31:0]      z_out
);

  localparam int          XW        = WIDTH + 2;
  localparam logic [4:0]  LAST_ITER = 5'(ITER - 1);
  localparam logic [31:0] QUARTER   = 32'h4000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           iter_q, iter_d;
  logic                 mode_q, mode_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [31:0]          z_q, z_d;
  logic signed [XW-1:0] xo_q, xo_d, yo_q, yo_d;
  logic [31:0]          zo_q, zo_d;

  // atan(2^-i) in binary-angle units (2^31 == pi), rounded to nearest.
  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_lut = 32'h2000_0000;
      5'd1:  atan_lut = 32'h12E4_051E;
      5'd2:  atan_lut = 32'h09FB_385B;
      5'd3:  atan_lut = 32'h0511_11D4;
      5'd4:  atan_lut = 32'h028B_0D43;
      5'd5:  atan_lut = 32'h0145_D7E1;
      5'd6:  atan_lut = 32'h00A2_F61E;
      5'd7:  atan_lut = 32'h0051_7C55;
      5'd8:  atan_lut = 32'h0028_BE53;
      5'd9:  atan_lut = 32'h0014_5F2F;
      5'd10: atan_lut = 32'h000A_2F98;
      5'd11: atan_lut = 32'h0005_17CC;
      5'd12: atan_lut = 32'h0002_8BE6;
      5'd13: atan_lut = 32'h0001_45F3;
      5'd14: atan_lut = 32'h0000_A2FA;
      5'd15: atan_lut = 32'h0000_517D;
      5'd16: atan_lut = 32'h0000_28BE;
      5'd17: atan_lut = 32'h0000_145F;
      5'd18: atan_lut = 32'h0000_0A30;
      5'd19: atan_lut = 32'h0000_0518;
      5'd20: atan_lut = 32'h0000_028C;
      5'd21: atan_lut = 32'h0000_0146;
      5'd22: atan_lut = 32'h0000_00A3;
      5'd23: atan_lut = 32'h0000_0051;
      5'd24: atan_lut = 32'h0000_0029;
      5'd25: atan_lut = 32'h0000_0014;
      5'd26: atan_lut = 32'h0000_000A;
      5'd27: atan_lut = 32'h0000_0005;
      5'd28: atan_lut = 32'h0000_0003;
      5'd29: atan_lut = 32'h0000_0001;
      5'd30: atan_lut = 32'h0000_0001;
      5'd31: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  // Pre-rotation by +/-90 degrees brings every operand into the
  // convergence range (about +/-99.9 degrees) of the micro-rotations.
  // Negating the most negative input is safe in the guard-extended width.
  logic signed [XW-1:0] x_ext, y_ext, pre_x, pre_y;
  logic [31:0]          pre_z;

  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

  always_comb begin
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = z_in;
    if (!mode) begin
      if (z_in[31:30] == 2'b01) begin
        pre_x = -y_ext;
        pre_y = x_ext;
        pre_z = z_in - QUARTER;
      end else if (z_in[31:30] == 2'b10) begin
        pre_x = y_ext;
        pre_y = -x_ext;
        pre_z = z_in + QUARTER;
      end
    end else if (x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        pre_x = y_ext;
        pre_y = -x_ext;
        pre_z = z_in + QUARTER;
      end else begin
        pre_x = -y_ext;
        pre_y = x_ext;
        pre_z = z_in - QUARTER;
      end
    end
  end

  // One micro-rotation; both shifted terms come from the old x/y values.
  logic signed [XW-1:0] x_sh, y_sh, step_x, step_y;
  logic [31:0]          step_z;
  logic                 dir_pos;

  assign x_sh    = x_q >>> iter_q;
  assign y_sh    = y_q >>> iter_q;
  assign dir_pos = mode_q ? y_q[XW-1] : ~z_q[31];

  always_comb begin
    if (dir_pos) begin
      step_x = x_q - y_sh;
      step_y = y_q + x_sh;
      step_z = z_q - atan_lut(iter_q);
    end else begin
      step_x = x_q + y_sh;
      step_y = y_q - x_sh;
      step_z = z_q + atan_lut(iter_q);
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    case (state_q)
      S_RUN: begin
        x_d    = step_x;
        y_d    = step_y;
        z_d    = step_z;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
          xo_d    = step_x;
          yo_d    = step_y;
          zo_d    = step_z;
          state_d = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          iter_d  = 5'd0;
          mode_d  = mode;
          x_d     = pre_x;
          y_d     = pre_y;
          z_d     = pre_z;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign x_out = xo_q;
  assign y_out = yo_q;
  assign z_out = zo_q;

endmodule
`default_nettype wire
